avrspi_master: RTL and testbench
================================

# avrspi_master

Initiator for the AVR-to-FPGA register SPI protocol: issues one register transaction per request, with the register-number byte under CS high and the data bytes under CS low. It returns the slave's status byte and the data read back. It drives the bus from the master side and is used both as the bench driver for the FPGA SPI slave and for FPGA-internal access to slave-register sets that speak the same protocol.

## Interface
- CLKDIV, 4: fclk cycles per SCK half-period. Must be ≥4 to meet slave 2-flop sync plus 1-cycle shift latency.
- fclk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock fclk
- req  in  1  start pulse; sampled only when busy=0
- regnum  in  8  register number ($10 kbd, $11 kbd strobe, $20–$23 mouse/kj, $30 reset, $40–$42 wait/glu/com, $50 cfg0, $60/$61 SD)
- len  in  3  data bytes 0..5; values 6/7 clamp to 5
- wdata  in  40  write data, sent LSB-first from bit 0; only bits [8*len-1:0] used
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- status  out  8  byte shifted in during regnum phase
- rdata  out  40  bytes shifted in during data phase; bit i = i-th received bit; bits ≥8*len cleared
- spics_n  out  1  SPI chip select, idle high
- spick  out  1  SPI clock, idle low
- spido  out  1  MOSI
- spidi  in  1  MISO; double-synchronised internally

## Operation
- Reset values: spics_n=1, spick=0, spido=0, busy=0, done=0, status=0, rdata=0, FSM=IDLE.
- IDLE: on req, latch regnum, clamped len, and wdata; busy←1; clear rdata.
- PRE: CS high, SCK low, 2*CLKDIV cycles.
- REG: 8 bits, regnum[0] first. Each bit:
  - SCK low CLKDIV cycles; MOSI driven on the first low cycle.
  - Synchronised MISO sampled on the last low cycle.
  - SCK high CLKDIV cycles.
  - Samples go to status, LSB-first.
- MID: spics_n←0 on the first cycle; hold with SCK low 2*CLKDIV cycles. The slave reloads its shift register on the CS fall.
- DATA: 8*len bits, same bit timing as REG; wdata LSB-first; samples into rdata[bitcount]. Skipped when len=0, which gives a pure CS-low pulse for $11/$30-style strobes.
- POST: spics_n←1 on the first cycle (slave commit/strobe edge); hold 2*CLKDIV cycles. Then done=1 for one cycle, busy←0, return to IDLE.
- req while busy: ignored, not queued.
- Bit counter is 6 bits; terminal count is 8*len−1 in DATA and 7 in REG.
- status is valid only if a previous transaction ended with a CS rise. The first transaction after power-up returns an undefined status.
- Async reset mid-transaction: outputs return to idle values immediately. The slave sees a CS rise, and the partial register write is accepted as a hazard. Reset is never a transaction abort mechanism.

## Timing
- SCK period 2*CLKDIV fclk; MOSI stable for the whole high phase.
- MISO sample point: last low cycle, synchronised value (2 fclk old). Valid for CLKDIV≥4 because slave output settles ≤3 fclk after SCK rise.
- Latency from accepted req to done: 2*CLKDIV*(3+8+8*len) cycles. CLKDIV=4, len=1 gives 152 cycles; len=0 gives 88.
- busy rises the cycle after req and falls with done; req in the done cycle is accepted next cycle.
- status and rdata are updated progressively and are stable from done until the next accepted req.

## Structure
- Shared package: FSM state encoding (IDLE, PRE, REG, MID, DATA, POST), MAX_BYTES=5, register-number constants.
- One sub-module: avrspi_phase_gen, the CLKDIV half-period counter producing sck_rise/sck_fall/sample_tick strobes, enabled by the FSM.

## Test plan
- regnum=$50, len=1, wdata=$A5 against the bench slave model → MOSI bit sequence 0,0,0,0,1,0,1,0 then 1,0,1,0,0,1,0,1; slave cfg0=$A5 after CS rise; done after 152 cycles.
- regnum=$10, len=5, wdata=$12_3456_789A → slave 40-bit kbd register = $12_3456_789A; 40 SCK pulses in the data phase.
- regnum=$41, len=1, slave read value $3C, preceding status $81 → rdata=$3C, status=$81.
- regnum=$30, len=0 → exactly 8 SCK pulses, CS low for 2*CLKDIV cycles, one slave strobe, done at cycle 88.
- req held high during busy plus len=7 → single transaction, clamped to 5 bytes.
- rst_n asserted mid-DATA → spics_n=1, spick=0, busy=0 asynchronously; next req completes normally.

Source files
------------

// File: rtl/avrspi_pkg.sv
// avrspi_pkg: shared definitions for the AVR-to-FPGA register SPI initiator.
//   state_e   - transaction FSM encoding (IDLE, PRE, REG, MID, DATA, POST)
//   regnum_e  - register numbers understood by the FPGA-side slave sets
//   MAX_BYTES - largest data phase in bytes; clamp_len() folds 6/7 onto it
package avrspi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_REG  = 3'd2,
      ST_MID  = 3'd3,
      ST_DATA = 3'd4,
      ST_POST = 3'd5
   } state_e;

   typedef enum logic [7:0] {
      REG_KBD     = 8'h10,
      REG_KBD_STB = 8'h11,
      REG_MOUSE0  = 8'h20,
      REG_MOUSE1  = 8'h21,
      REG_MOUSE2  = 8'h22,
      REG_KJ      = 8'h23,
      REG_RESET   = 8'h30,
      REG_WAIT    = 8'h40,
      REG_GLU     = 8'h41,
      REG_COM     = 8'h42,
      REG_CFG0    = 8'h50,
      REG_SD0     = 8'h60,
      REG_SD1     = 8'h61
   } regnum_e;

   localparam logic [2:0] MAX_BYTES = 3'd5;

   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      return (len > MAX_BYTES) ? MAX_BYTES : len;
   endfunction

endpackage

// File: rtl/avrspi_phase_gen.sv
// avrspi_phase_gen: SCK period timer. Counts 0..2*CLKDIV-1 while enabled and
// sits at 0 while disabled, so the first period starts the cycle after en rises.
//   fclk, rst_n  - clock, async active-low reset
//   en           - count enable (FSM not idle)
//   sck_rise     - last low cycle of the period: SCK goes high at this edge
//   sample_tick  - MISO sample point, coincident with sck_rise
//   sck_fall     - last cycle of the period: SCK goes low / slot ends
module avrspi_phase_gen #(
   parameter int CLKDIV = 4
) (
   input  logic fclk,
   input  logic rst_n,
   input  logic en,
   output logic sck_rise,
   output logic sample_tick,
   output logic sck_fall
);

   localparam int CW = $clog2(2 * CLKDIV);
   localparam logic [CW-1:0] HALF_END = CW'(CLKDIV - 1);
   localparam logic [CW-1:0] FULL_END = CW'(2 * CLKDIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (en && (cnt_q != FULL_END)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign sck_rise    = en && (cnt_q == HALF_END);
   assign sample_tick = en && (cnt_q == HALF_END);
   assign sck_fall    = en && (cnt_q == FULL_END);

endmodule

// File: rtl/avrspi_master.sv
// avrspi_master: one register transaction per request. The register number
// goes out with CS high (status byte comes back), then CS drops for 0..5 data
// bytes (read data comes back), then CS rises to commit.
//   fclk, rst_n          - clock, async active-low reset
//   req, regnum, len,    - request; sampled only while busy=0
//   wdata                  (len 6/7 clamp to 5; wdata sent LSB-first)
//   busy, done           - busy high from the cycle after an accepted req until
//                          done; done is a one-cycle pulse. req while busy is
//                          dropped, never queued.
//   status, rdata        - bytes received in the REG / DATA phases
//   spics_n, spick,      - SPI bus (CS idle high, SCK idle low)
//   spido, spidi
//   dbg_state            - current FSM state
module avrspi_master import avrspi_pkg::*; #(
   parameter int CLKDIV = 4
) (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [7:0]  regnum,
   input  logic [2:0]  len,
   input  logic [39:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [7:0]  status,
   output logic [39:0] rdata,
   output logic        spics_n,
   output logic        spick,
   output logic        spido,
   input  logic        spidi,
   output state_e      dbg_state
);

   state_e      state_q, state_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [7:0]  status_q, status_d;
   logic [39:0] rdata_q, rdata_d;
   logic        spics_n_q, spics_n_d, spick_q, spick_d, spido_q, spido_d;
   logic [7:0]  reg_sh_q, reg_sh_d;
   logic [39:0] dat_sh_q, dat_sh_d;
   logic [2:0]  len_q, len_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic        spidi_s1_q, spidi_s2_q;
   logic        sck_rise, sample_tick, sck_fall;

   avrspi_phase_gen #(.CLKDIV(CLKDIV)) u_phase (
      .fclk        (fclk),
      .rst_n       (rst_n),
      .en          (state_q != ST_IDLE),
      .sck_rise    (sck_rise),
      .sample_tick (sample_tick),
      .sck_fall    (sck_fall)
   );

   // Every slot (PRE/MID/POST hold, or one bit) is exactly one phase-gen
   // period, so state changes happen only on sck_fall. MOSI is always taken
   // from bit 0 of a shift register and updated on the fall edge, which keeps
   // it stable across the whole high phase.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      status_d  = status_q;
      rdata_d   = rdata_q;
      spics_n_d = spics_n_q;
      spick_d   = spick_q;
      spido_d   = spido_q;
      reg_sh_d  = reg_sh_q;
      dat_sh_d  = dat_sh_q;
      len_d     = len_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d  = ST_PRE;
               busy_d   = 1'b1;
               reg_sh_d = regnum;
               dat_sh_d = wdata;
               len_d    = clamp_len(len);
               rdata_d  = '0;
            end
         end
         ST_PRE: begin
            if (sck_fall) begin
               state_d   = ST_REG;
               bit_cnt_d = '0;
               spido_d   = reg_sh_q[0];
               reg_sh_d  = reg_sh_q >> 1;
            end
         end
         ST_REG: begin
            if (sck_rise) spick_d = 1'b1;
            if (sample_tick) status_d[bit_cnt_q[2:0]] = spidi_s2_q;
            if (sck_fall) begin
               spick_d = 1'b0;
               if (bit_cnt_q == 6'd7) begin
                  state_d   = ST_MID;
                  spics_n_d = 1'b0;
                  spido_d   = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  spido_d   = reg_sh_q[0];
                  reg_sh_d  = reg_sh_q >> 1;
               end
            end
         end
         ST_MID: begin
            if (sck_fall) begin
               if (len_q == 3'd0) begin
                  // Strobe-only access: CS low for just the MID slot.
                  state_d   = ST_POST;
                  spics_n_d = 1'b1;
               end else begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
                  spido_d   = dat_sh_q[0];
                  dat_sh_d  = dat_sh_q >> 1;
               end
            end
         end
         ST_DATA: begin
            if (sck_rise) spick_d = 1'b1;
            if (sample_tick) rdata_d[bit_cnt_q] = spidi_s2_q;
            if (sck_fall) begin
               spick_d = 1'b0;
               // Last bit index is 8*len-1, i.e. {len-1, 3'b111}.
               if (bit_cnt_q == {len_q - 3'd1, 3'b111}) begin
                  state_d   = ST_POST;
                  spics_n_d = 1'b1;
                  spido_d   = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  spido_d   = dat_sh_q[0];
                  dat_sh_d  = dat_sh_q >> 1;
               end
            end
         end
         ST_POST: begin
            if (sck_fall) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         status_q   <= '0;
         rdata_q    <= '0;
         spics_n_q  <= 1'b1;
         spick_q    <= 1'b0;
         spido_q    <= 1'b0;
         reg_sh_q   <= '0;
         dat_sh_q   <= '0;
         len_q      <= '0;
         bit_cnt_q  <= '0;
         spidi_s1_q <= 1'b0;
         spidi_s2_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         status_q   <= status_d;
         rdata_q    <= rdata_d;
         spics_n_q  <= spics_n_d;
         spick_q    <= spick_d;
         spido_q    <= spido_d;
         reg_sh_q   <= reg_sh_d;
         dat_sh_q   <= dat_sh_d;
         len_q      <= len_d;
         bit_cnt_q  <= bit_cnt_d;
         spidi_s1_q <= spidi;
         spidi_s2_q <= spidi_s1_q;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign status    = status_q;
   assign rdata     = rdata_q;
   assign spics_n   = spics_n_q;
   assign spick     = spick_q;
   assign spido     = spido_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_avrspi_master.sv
// tb_avrspi_master: directed transactions against a behavioural register slave.
// Expected status/rdata/latency are queued when a request is issued and checked
// by a monitor on each done pulse; slave-side effects are checked afterwards.
module tb_avrspi_master;
   import avrspi_pkg::*;

   localparam int CLKDIV = 4;

   // ---------------- clock / reset / DUT ----------------
   logic        fclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [7:0]  regnum_i = '0;
   logic [2:0]  len_i = '0;
   logic [39:0] wdata_i = '0;
   logic        busy, done, spics_n, spick, spido, spidi;
   logic [7:0]  status;
   logic [39:0] rdata;
   state_e      dbg_state;

   always #5 fclk = ~fclk;

   avrspi_master #(.CLKDIV(CLKDIV)) dut (
      .fclk      (fclk),
      .rst_n     (rst_n),
      .req       (req),
      .regnum    (regnum_i),
      .len       (len_i),
      .wdata     (wdata_i),
      .busy      (busy),
      .done      (done),
      .status    (status),
      .rdata     (rdata),
      .spics_n   (spics_n),
      .spick     (spick),
      .spido     (spido),
      .spidi     (spidi),
      .dbg_state (dbg_state)
   );

   // ---------------- counters / check helper ----------------
   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_miss++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
      end
   endtask

   // ---------------- behavioural slave ----------------
   logic [39:0] sl_regs [256];
   logic [7:0]  sl_regnum_rx = '0;
   logic [7:0]  sl_status_sh = '0;
   logic [7:0]  sl_status_next = 8'h1E;
   logic [39:0] sl_data_sh = '0;
   logic [39:0] sl_data_rx = '0;
   int          sl_bits = 0;
   int          sl_strobes = 0;
   int          sl_sck_total = 0;
   int          sl_data_sck = 0;

   assign spidi = spics_n ? sl_status_sh[0] : sl_data_sh[0];

   always @(posedge spick) begin
      sl_sck_total++;
      if (spics_n) begin
         sl_regnum_rx = {spido, sl_regnum_rx[7:1]};
         sl_status_sh = sl_status_sh >> 1;
      end else begin
         if (sl_bits < 40) sl_data_rx[sl_bits] = spido;
         sl_bits++;
         sl_data_sck++;
         sl_data_sh = sl_data_sh >> 1;
      end
   end

   always @(negedge spics_n) begin
      sl_data_sh = sl_regs[sl_regnum_rx];
      sl_data_rx = '0;
      sl_bits    = 0;
   end

   always @(posedge spics_n) begin
      if (sl_bits == 0) sl_strobes++;
      else              sl_regs[sl_regnum_rx] = sl_data_rx;
      sl_status_sh = sl_status_next;
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct packed {
      logic [7:0]  status;
      logic        chk_status;
      logic [39:0] rdata;
      logic [15:0] latency;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   t_acc = 0;
   int   cs_low_cyc = 0;
   logic busy_prev = 1'b0;

   always @(negedge fclk) begin
      cyc++;
      if (spics_n === 1'b0) cs_low_cyc++;
      if (busy === 1'b1 && busy_prev !== 1'b1) t_acc = cyc;
      busy_prev = busy;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_done actual=done required=no_done at cycle %0d", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rdata", 64'(rdata), 64'(mon_e.rdata));
            if (mon_e.chk_status) chk("status", 64'(status), 64'(mon_e.status));
            chk("latency", 64'(cyc - t_acc), 64'(mon_e.latency));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input logic [7:0] rn, input logic [2:0] ln, input logic [39:0] wd,
                        input logic [39:0] exp_rd, input logic chk_st, input logic [7:0] exp_st,
                        input int lat, input bit hold);
      exp_t e;
      bit   got;
      e.status     = exp_st;
      e.chk_status = chk_st;
      e.rdata      = exp_rd;
      e.latency    = 16'(lat);
      exp_q.push_back(e);
      @(negedge fclk);
      regnum_i = rn;
      len_i    = ln;
      wdata_i  = wd;
      req      = 1'b1;
      if (!hold) begin
         @(negedge fclk);
         req = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge fclk);
         if (done === 1'b1) got = 1'b1;
      end
      req = 1'b0;
      if (!got) begin
         n_vec++;
         n_miss++;
         $display("FAIL done_timeout actual=no_done required=done regnum=%0h", rn);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      n_miss++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // ---------------- stimulus ----------------
   int  strobes0, sck0, cs0;
   bit  seen, ok;

   initial begin
      for (int i = 0; i < 256; i++) sl_regs[i] = '0;

      // Reset values
      #23;
      chk("rst_spics_n", 64'(spics_n), 64'(1));
      chk("rst_spick", 64'(spick), 64'(0));
      chk("rst_spido", 64'(spido), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_status", 64'(status), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge fclk);
      rst_n = 1'b1;
      repeat (3) @(negedge fclk);

      // T1: cfg0 write $A5, 1 byte; first status after power-up not checked
      sl_regs[8'h50] = 40'h77;
      sl_data_sck = 0;
      issue(8'h50, 3'd1, 40'hA5, 40'h77, 1'b0, 8'h00, 152, 1'b0);
      chk("t1_slave_regnum", 64'(sl_regnum_rx), 64'h50);
      chk("t1_slave_cfg0", 64'(sl_regs[8'h50]), 64'hA5);
      chk("t1_data_sck", 64'(sl_data_sck), 64'd8);

      // T2: 40-bit kbd write, status from T1's CS rise
      sl_status_next = 8'h81;
      sl_regs[8'h10] = 40'hCA_FEBA_BE55;
      sl_data_sck = 0;
      issue(8'h10, 3'd5, 40'h12_3456_789A, 40'hCA_FEBA_BE55, 1'b1, 8'h1E, 408, 1'b0);
      chk("t2_slave_kbd", 64'(sl_regs[8'h10]), 64'h12_3456_789A);
      chk("t2_data_sck", 64'(sl_data_sck), 64'd40);

      // T3: glu read $3C, status $81; only wdata[7:0] goes out
      sl_status_next = 8'hB4;
      sl_regs[8'h41] = 40'h3C;
      issue(8'h41, 3'd1, 40'hFF_FFFF_FF5A, 40'h3C, 1'b1, 8'h81, 152, 1'b0);
      chk("t3_slave_glu", 64'(sl_regs[8'h41]), 64'h5A);

      // T4: len=0 reset strobe
      sl_status_next = 8'h6D;
      strobes0 = sl_strobes;
      sck0 = sl_sck_total;
      cs0 = cs_low_cyc;
      sl_data_sck = 0;
      issue(8'h30, 3'd0, 40'hFF, 40'h0, 1'b1, 8'hB4, 88, 1'b0);
      chk("t4_strobes", 64'(sl_strobes - strobes0), 64'd1);
      chk("t4_sck_total", 64'(sl_sck_total - sck0), 64'd8);
      chk("t4_cs_low_cycles", 64'(cs_low_cyc - cs0), 64'(2 * CLKDIV));
      chk("t4_data_sck", 64'(sl_data_sck), 64'd0);

      // T5: req held through busy, len=7 clamps to 5 bytes
      sl_status_next = 8'h3A;
      sl_regs[8'h21] = 40'h01_2345_6789;
      sl_data_sck = 0;
      issue(8'h21, 3'd7, 40'hF0_E1D2_C3B4, 40'h01_2345_6789, 1'b1, 8'h6D, 408, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge fclk);
         if (busy !== 1'b0) seen = 1'b1;
      end
      chk("t5_no_requeue", 64'(seen), 64'(0));
      chk("t5_data_sck", 64'(sl_data_sck), 64'd40);
      chk("t5_slave_reg", 64'(sl_regs[8'h21]), 64'hF0_E1D2_C3B4);
      chk("t5_queue_empty", 64'(exp_q.size()), 64'(0));

      // T6: async reset in the middle of the data phase, SCK high
      sl_status_next = 8'hC5;
      sl_regs[8'h22] = 40'h11_1111_1111;
      sl_data_sck = 0;
      @(negedge fclk);
      regnum_i = 8'h22;
      len_i    = 3'd5;
      wdata_i  = 40'hDE_ADBE_EF01;
      req      = 1'b1;
      @(negedge fclk);
      req = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge fclk);
         if (sl_data_sck >= 3 && spick === 1'b1) ok = 1'b1;
      end
      chk("t6_reached_data", 64'(ok), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("t6_spics_n", 64'(spics_n), 64'(1));
      chk("t6_spick", 64'(spick), 64'(0));
      chk("t6_busy", 64'(busy), 64'(0));
      chk("t6_rdata", 64'(rdata), 64'(0));
      chk("t6_state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge fclk);
      rst_n = 1'b1;
      repeat (3) @(negedge fclk);

      // T7: normal transaction after reset; status loaded by the reset CS rise
      sl_regs[8'h60] = 40'hA55A;
      issue(8'h60, 3'd2, 40'hBEEF, 40'hA55A, 1'b1, 8'hC5, 216, 1'b0);
      chk("t7_slave_sd", 64'(sl_regs[8'h60]), 64'hBEEF);

      repeat (5) @(negedge fclk);
      chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
